// File: rtl/onchip_mem_arbiter.sv
// -----------------------------------------------------------------------------
// onchip_mem_arbiter
//   Shares one single-port on-chip RAM between two Avalon-MM masters:
//   port 0 = Nios II data master, port 1 = graphics/DMA reader.
//   At most one request is granted per cycle. The grant is combinational and
//   the granted master's address/byteenable/writedata pass straight to the RAM.
//   Read data returns one cycle after acceptance with readdatavalid.
//   Addresses >= DEPTH are accepted, but writes are dropped and reads return 0.
//
// Ports (x = 0, 1)
//   clk, reset          : clock, asynchronous active-high reset
//   mx_address/byteenable/read/write/writedata : master request inputs
//   mx_waitrequest      : high when the master is not granted this cycle
//   mx_readdata/readdatavalid : one-cycle read return to the requesting master
//   ram_address/byteenable/chipselect/write/writedata/clken : RAM drive
//   ram_readdata        : RAM output, valid the cycle after the address
//
// Configuration
//   ONCHIP_ARB_FIXED_PRI_EN : when defined, port 0 always wins and the
//   round-robin state stays at its reset value. When undefined, arbitration
//   is round-robin with at most MAX_HOLD back-to-back grants under contention.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module onchip_mem_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 20480,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     ram_address,
  output logic [DATA_W/8-1:0]   ram_byteenable,
  output logic                  ram_chipselect,
  output logic                  ram_write,
  output logic [DATA_W-1:0]     ram_writedata,
  output logic                  ram_clken,
  input  logic [DATA_W-1:0]     ram_readdata
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] MAX_HOLD_C = HW'(MAX_HOLD);

  logic          req0, req1, grant_any;
  logic          win;            // index of the granted master (valid when grant_any)
  logic          owner_q, owner_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rd_v_q, rd_id_q, rd_oor_q;

  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W/8-1:0] sel_be;
  logic [DATA_W-1:0]   sel_wd;
  logic                sel_wr, sel_rd, in_range;
  logic [DATA_W-1:0]   ret_data;

  assign req0      = m0_read | m0_write;
  assign req1      = m1_read | m1_write;
  assign grant_any = req0 | req1;

`ifdef ONCHIP_ARB_FIXED_PRI_EN
  // Port 0 always wins; port 1 only gets the RAM when port 0 is idle.
  assign win     = ~req0;
  assign owner_d = owner_q;
  assign hold_d  = hold_q;
`else
  always_comb begin
    owner_d = owner_q;
    hold_d  = hold_q;
    // Under contention the current owner keeps the RAM until it has used
    // MAX_HOLD consecutive grants; a lone requester always wins.
    if (req0 && req1) begin
      win = (hold_q < MAX_HOLD_C) ? owner_q : ~owner_q;
    end else begin
      win = req1;
    end
    if (!grant_any) begin
      hold_d = '0;
    end else if (win == owner_q) begin
      hold_d = (hold_q == MAX_HOLD_C) ? hold_q : hold_q + 1'b1;
    end else begin
      owner_d = win;
      hold_d  = HW'(1);
    end
  end
`endif

  // Granted request; read+write together counts as a write.
  assign sel_addr = win ? m1_address    : m0_address;
  assign sel_be   = win ? m1_byteenable : m0_byteenable;
  assign sel_wd   = win ? m1_writedata  : m0_writedata;
  assign sel_wr   = win ? m1_write      : m0_write;
  assign sel_rd   = (win ? m1_read : m0_read) & ~sel_wr;
  assign in_range = ({{(32-ADDR_W){1'b0}}, sel_addr} < 32'(DEPTH));

  assign m0_waitrequest = ~(grant_any & ~win);
  assign m1_waitrequest = ~(grant_any &  win);

  assign ram_address    = grant_any ? sel_addr : '0;
  assign ram_byteenable = grant_any ? sel_be   : '0;
  assign ram_writedata  = grant_any ? sel_wd   : '0;
  assign ram_chipselect = grant_any & in_range;
  assign ram_write      = ram_chipselect & sel_wr;
  assign ram_clken      = 1'b1;

  // Out-of-range reads still complete, with zero data.
  assign ret_data         = rd_oor_q ? '0 : ram_readdata;
  assign m0_readdatavalid = rd_v_q & ~rd_id_q;
  assign m1_readdatavalid = rd_v_q &  rd_id_q;
  assign m0_readdata      = m0_readdatavalid ? ret_data : '0;
  assign m1_readdata      = m1_readdatavalid ? ret_data : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner_q  <= 1'b0;
      hold_q   <= '0;
      rd_v_q   <= 1'b0;
      rd_id_q  <= 1'b0;
      rd_oor_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      hold_q   <= hold_d;
      rd_v_q   <= grant_any & sel_rd;
      rd_id_q  <= win;
      rd_oor_q <= ~in_range;
    end
  end

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
`timescale 1ns/1ps
module tb_onchip_mem_arbiter;

  localparam int ADDR_W   = 15;
  localparam int DATA_W   = 32;
  localparam int DEPTH    = 20480;
  localparam int MAX_HOLD = 4;
`ifdef ONCHIP_ARB_FIXED_PRI_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [ADDR_W-1:0] m0_address, m1_address, ram_address;
  logic [3:0]  m0_byteenable, m1_byteenable, ram_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic [31:0] m0_writedata, m1_writedata, ram_writedata;
  logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic [31:0] m0_readdata, m1_readdata, ram_readdata;
  logic        ram_chipselect, ram_write, ram_clken;

  always #5 clk = ~clk;

  onchip_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable), .ram_chipselect(ram_chipselect),
    .ram_write(ram_write), .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  // Synchronous single-port RAM: data appears the cycle after the address.
  logic [31:0] ram_mem [0:DEPTH-1] = '{default: 32'h0};
  logic [31:0] ram_q = 32'h0;
  assign ram_readdata = ram_q;
  always @(posedge clk) begin
    if (ram_chipselect) begin
      if (ram_write) begin
        for (int b = 0; b < 4; b++)
          if (ram_byteenable[b]) ram_mem[ram_address][8*b +: 8] <= ram_writedata[8*b +: 8];
      end else begin
        ram_q <= ram_mem[ram_address];
      end
    end
  end

  // Reference model: expected memory contents and round-robin history.
  logic [31:0] ref_mem [0:DEPTH-1] = '{default: 32'h0};
  int m_last;     // master that received the most recent grant
  int m_streak;   // consecutive grants that master has received
  int last_grant;

  // Staged requests for the next cycle.
  logic        s_rd [2];
  logic        s_wr [2];
  logic [14:0] s_addr [2];
  logic [3:0]  s_be [2];
  logic [31:0] s_wd [2];

  int checks = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int p, input logic rd, input logic wr, input int addr,
                         input logic [3:0] be, input logic [31:0] wd);
    s_rd[p] = rd; s_wr[p] = wr; s_addr[p] = 15'(addr); s_be[p] = be; s_wd[p] = wd;
  endtask

  task automatic clear_reqs();
    for (int p = 0; p < 2; p++) set_req(p, 1'b0, 1'b0, 0, 4'h0, 32'h0);
  endtask

  task automatic drive_inputs();
    m0_read = s_rd[0]; m0_write = s_wr[0]; m0_address = s_addr[0];
    m0_byteenable = s_be[0]; m0_writedata = s_wd[0];
    m1_read = s_rd[1]; m1_write = s_wr[1]; m1_address = s_addr[1];
    m1_byteenable = s_be[1]; m1_writedata = s_wd[1];
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset();
    clear_reqs();
    drive_inputs();
    reset = 1'b1;
    #1;
    check("rst_m0_wait", m0_waitrequest, 1'b1);
    check("rst_m1_wait", m1_waitrequest, 1'b1);
    check("rst_m0_rdv", m0_readdatavalid, 1'b0);
    check("rst_m1_rdv", m1_readdatavalid, 1'b0);
    check("rst_m0_rdata", m0_readdata, 32'h0);
    check("rst_m1_rdata", m1_readdata, 32'h0);
    check("rst_cs", ram_chipselect, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    m_last = 0;
    m_streak = 0;
  endtask

  // One bus cycle: apply staged requests, check grant and RAM drive against
  // the model, then check the read return one cycle later.
  task automatic cycle();
    int win;
    logic req0, req1, wr, rd, inr, exp_v;
    int exp_id;
    logic [14:0] a;
    logic [31:0] exp_data;
    @(negedge clk);
    drive_inputs();
    #1;
    req0 = s_rd[0] | s_wr[0];
    req1 = s_rd[1] | s_wr[1];
    if (req0 && req1) win = FIXED ? 0 : ((m_streak < MAX_HOLD) ? m_last : 1 - m_last);
    else if (req0) win = 0;
    else if (req1) win = 1;
    else win = -1;
    last_grant = win;
    check("m0_wait", m0_waitrequest, win != 0);
    check("m1_wait", m1_waitrequest, win != 1);
    exp_v = 1'b0; exp_id = 0; exp_data = 32'h0;
    if (win >= 0) begin
      a   = s_addr[win];
      wr  = s_wr[win];
      rd  = s_rd[win] & ~wr;
      inr = (int'(a) < DEPTH);
      check("ram_cs", ram_chipselect, inr);
      check("ram_wr", ram_write, inr & wr);
      check("ram_addr", ram_address, a);
      if (wr) begin
        check("ram_wdata", ram_writedata, s_wd[win]);
        check("ram_be", ram_byteenable, s_be[win]);
      end
      exp_v = rd; exp_id = win;
      exp_data = inr ? ref_mem[a] : 32'h0;
      if (wr && inr)
        for (int b = 0; b < 4; b++)
          if (s_be[win][b]) ref_mem[a][8*b +: 8] = s_wd[win][8*b +: 8];
      if (win == m_last) m_streak = (m_streak < MAX_HOLD) ? m_streak + 1 : MAX_HOLD;
      else begin m_last = win; m_streak = 1; end
    end else begin
      check("idle_cs", ram_chipselect, 1'b0);
      check("idle_wr", ram_write, 1'b0);
      check("idle_addr", ram_address, 15'h0);
      m_streak = 0;
    end
    @(posedge clk);
    #1;
    check("m0_rdv", m0_readdatavalid, exp_v && exp_id == 0);
    check("m1_rdv", m1_readdatavalid, exp_v && exp_id == 1);
    check("m0_rdata", m0_readdata, (exp_v && exp_id == 0) ? exp_data : 32'h0);
    check("m1_rdata", m1_readdata, (exp_v && exp_id == 1) ? exp_data : 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int k0, k1;
    clear_reqs();
    drive_inputs();
    #2;
    do_reset();

    // Reset and idle
    cycle();
    cycle();

    // Single-master round trip
    set_req(0, 1'b0, 1'b1, 'h10, 4'hF, 32'hDEADBEEF); cycle();
    set_req(0, 1'b1, 1'b0, 'h10, 4'h0, 32'h0);        cycle();
    check("rt_rdata", m0_readdata, 32'hDEADBEEF);
    check("rt_rdv", m0_readdatavalid, 1'b1);
    clear_reqs(); cycle();

    // Byte lanes
    set_req(0, 1'b0, 1'b1, 'h20, 4'hF, 32'h11223344);   cycle();
    set_req(0, 1'b0, 1'b1, 'h20, 4'b0101, 32'hAABBCCDD); cycle();
    set_req(0, 1'b1, 1'b0, 'h20, 4'h0, 32'h0);           cycle();
    check("be_rdata", m0_readdata, 32'h11BB33DD);
    clear_reqs();

    // Out of range on port 1
    set_req(1, 1'b0, 1'b1, DEPTH, 4'hF, 32'h5); cycle();
    set_req(1, 1'b1, 1'b0, DEPTH, 4'h0, 32'h0); cycle();
    check("oor_rdv", m1_readdatavalid, 1'b1);
    check("oor_rdata", m1_readdata, 32'h0);
    set_req(1, 1'b1, 1'b0, 0, 4'h0, 32'h0);     cycle();
    check("addr0_rdata", m1_readdata, 32'h0);
    clear_reqs(); cycle();

    // Contention from reset: both masters stream reads
    for (int i = 0; i < 64; i++) begin
      set_req(0, 1'b0, 1'b1, 'h100 + i, 4'hF, 32'hC0DE0000 + i);
      cycle();
    end
    clear_reqs();
    do_reset();
    for (int k = 0; k < 12; k++) begin
      set_req(0, 1'b1, 1'b0, 'h100 + k, 4'h0, 32'h0);
      set_req(1, 1'b1, 1'b0, 'h120 + k, 4'h0, 32'h0);
      cycle();
      check("arb_order", last_grant, FIXED ? 0 : (k / 4) % 2);
      if (FIXED) check("fixed_m1_wait", m1_waitrequest, 1'b1);
    end
    clear_reqs(); cycle();

    // Randomized traffic on both ports
    for (int n = 0; n < 300; n++) begin
      for (int p = 0; p < 2; p++) begin
        k0 = $urandom_range(0, 3);
        k1 = ($urandom_range(0, 9) == 0) ? DEPTH + $urandom_range(0, 15) : $urandom_range(0, 31);
        set_req(p, k0[0], k0[1], k1, 4'($urandom_range(0, 15)), $urandom);
      end
      cycle();
    end
    clear_reqs(); cycle();

    // Reset while a read return is in flight
    set_req(0, 1'b0, 1'b1, 'h30, 4'hF, 32'hCAFEF00D); cycle();
    set_req(0, 1'b1, 1'b0, 'h30, 4'h0, 32'h0);
    @(negedge clk);
    drive_inputs();
    @(posedge clk);
    #1;
    check("pre_rst_rdv", m0_readdatavalid, 1'b1);
    check("pre_rst_rdata", m0_readdata, 32'hCAFEF00D);
    do_reset();
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
